rx_comma_align_ctrl: RTL and testbench
======================================

// Module: rx_comma_align_ctrl
// PURPOSE
//  Per-channel comma-alignment controller for the 1G (1000BASE-X) GT receive path.
//  Hunts for K28.5 while driving rxcommaalignen, releases alignment once lock is verified,
//  and re-arms the hunt after a burst of code errors.
//  rxcommaalignen_out feeds the GT port and the GPI bit-mapping stage that places it on the GPIO bus.
// PARAMETERS
//  DATA_BYTES   2     byte lanes per rxdata word (1 or 2)
//  LOCK_COMMAS  4     consecutive error-free commas (VERIFY) required to reach LOCKED
//  ERR_THRESH   4     code errors inside one ERR_WINDOW that force loss of lock
//  ERR_WINDOW   1024  cycles per error-count window in LOCKED
//  HUNT_TMO     65535 cycles in VERIFY without a comma before returning to HUNT
// PORTS
//  clk                  in   1            GT rxusrclk2 domain clock
//  rst                  in   1            asynchronous, active-high reset
//  enable               in   1            0 forces IDLE (alignen low)
//  rxdata               in   8*DATA_BYTES decoded receive data
//  rxcharisk            in   DATA_BYTES   per-lane K flag
//  rxdisperr            in   DATA_BYTES   per-lane disparity error
//  rxnotintable         in   DATA_BYTES   per-lane not-in-table error
//  rxbyteisaligned      in   1            GT byte-aligned status
//  rxcommaalignen_out   out  1            comma-align enable to GT / GPI mapper
//  aligned              out  1            1 while in LOCKED
//  align_state          out  2            0 IDLE, 1 HUNT, 2 VERIFY, 3 LOCKED
//  loss_count           out  16           LOCKED->HUNT transitions, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset: state IDLE, rxcommaalignen_out=0, aligned=0, align_state=0, loss_count=0, all counters 0.
//  - All outputs are registered and follow the state register (1-cycle latency from the causing input).
//  - comma = any lane with rxcharisk=1 and byte==8'hBC; err = OR over lanes of (rxdisperr|rxnotintable).
//  - IDLE:   alignen=0. enable=1 -> HUNT.
//  - HUNT:   alignen=1. comma && rxbyteisaligned && !err -> VERIFY, with comma_cnt=1 and tmo_cnt=0.
//  - VERIFY: alignen=1.
//      - err, or !rxbyteisaligned -> HUNT.
//      - comma -> comma_cnt+1; reaching LOCK_COMMAS -> LOCKED with err_cnt=0 and win_cnt=0.
//      - tmo_cnt counts cycles without a comma and clears on each comma; reaching HUNT_TMO -> HUNT.
//  - LOCKED: alignen=0, aligned=1.
//      - win_cnt counts 0..ERR_WINDOW-1; on wrap, err_cnt clears.
//      - err increments err_cnt, saturating. err_cnt reaching ERR_THRESH -> HUNT and loss_count+1.
//      - Wrap and err in the same cycle: err_cnt := 1.
//      - !rxbyteisaligned -> HUNT and loss_count+1.
//  - enable=0 in any state -> IDLE next cycle; takes priority over every other transition.
//    loss_count is kept (cleared only by rst).
//  - Simultaneous comma and err in VERIFY: err wins (-> HUNT).
//  - Reset mid-operation: asynchronous return to reset values. No partial counts survive.
//  - Counter widths: $clog2 of each limit (+1 where the limit itself is reached).
// STRUCTURE
//  - Package rx_align_pkg: state encoding localparams (ST_IDLE..ST_LOCKED) and K28_5 = 8'hBC.
//  - Sub-module comma_lane_detect: combinational per-lane comma/err detection,
//    OR-reduced across DATA_BYTES.
//  - Top level holds the FSM, comma/timeout/window/error counters and the output registers.
// TESTING
//  - Reset, then enable=1 with idle pattern (lane0 K28.5, lane1 D16.2=8'h50), rxbyteisaligned=1
//    -> HUNT next cycle, VERIFY after the first comma, LOCKED after 4 commas;
//    alignen falls, aligned rises on the same edge.
//  - In VERIFY, assert rxdisperr[1] together with a comma
//    -> HUNT next cycle, alignen stays 1, loss_count unchanged.
//  - In LOCKED, inject 4 rxnotintable pulses within 1024 cycles
//    -> HUNT after the 4th; loss_count=1; alignen=1.
//  - In LOCKED, inject 3 errors, let the window wrap, then inject 3 more -> remains LOCKED.
//  - In VERIFY, stop commas for 65535 cycles -> HUNT. Then drop enable -> IDLE, alignen=0.
//  - Assert rst while LOCKED with loss_count=5 -> all outputs 0 immediately.
//    Additionally, force loss_count to 16'hFFFF, then cause a loss -> loss_count stays 16'hFFFF.

Source files
------------

// File: rtl/rx_align_pkg.sv
// Shared constants for the 1G receive comma-alignment controller.
// State encoding doubles as the align_state output value.
package rx_align_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HUNT   = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_LOCKED = 2'd3;

    localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/rx_comma_align_ctrl_lane_detect.sv
// Per-lane K28.5 and code-error detection, OR-reduced across lanes.
// Purely combinational; the controller registers everything downstream.
module comma_lane_detect
    import rx_align_pkg::*;
#(
    parameter int DATA_BYTES = 2
) (
    input  logic [8*DATA_BYTES-1:0] i_rxdata,
    input  logic [DATA_BYTES-1:0]   i_charisk,
    input  logic [DATA_BYTES-1:0]   i_disperr,
    input  logic [DATA_BYTES-1:0]   i_notintable,
    output logic                    o_comma,
    output logic                    o_err
);

    // Any lane carrying a K28.5 is a comma; any lane error is an error
    always_comb begin
        o_comma = 1'b0;
        o_err   = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i_charisk[i] && (i_rxdata[8*i +: 8] == K28_5)) begin
                o_comma = 1'b1;
            end
            if (i_disperr[i] || i_notintable[i]) begin
                o_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_comma_align_ctrl.sv
// Comma-alignment controller: hunts for K28.5, verifies lock,
// releases rxcommaalignen while locked and re-hunts on error bursts.
module rx_comma_align_ctrl
    import rx_align_pkg::*;
#(
    parameter int DATA_BYTES  = 2,
    parameter int LOCK_COMMAS = 4,
    parameter int ERR_THRESH  = 4,
    parameter int ERR_WINDOW  = 1024,
    parameter int HUNT_TMO    = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [8*DATA_BYTES-1:0] rxdata,
    input  logic [DATA_BYTES-1:0]   rxcharisk,
    input  logic [DATA_BYTES-1:0]   rxdisperr,
    input  logic [DATA_BYTES-1:0]   rxnotintable,
    input  logic                    rxbyteisaligned,
    output logic                    rxcommaalignen_out,
    output logic                    aligned,
    output logic [1:0]              align_state,
    output logic [15:0]             loss_count
);

    localparam int CW = $clog2(LOCK_COMMAS) + 1;
    localparam int TW = $clog2(HUNT_TMO) + 1;
    localparam int WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int EW = $clog2(ERR_THRESH) + 1;

    localparam logic [CW-1:0] LC_LIM  = CW'(LOCK_COMMAS);
    localparam logic [TW-1:0] TMO_LIM = TW'(HUNT_TMO);
    localparam logic [WW-1:0] WIN_MAX = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] ERR_LIM = EW'(ERR_THRESH);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_comma_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [WW-1:0] r_win_cnt;
    logic [EW-1:0] r_err_cnt;
    logic [15:0]   r_loss_cnt;

    logic          w_comma;
    logic          w_err;
    logic          w_loss;
    logic          w_wrap;
    logic [CW-1:0] w_comma_inc;
    logic [TW-1:0] w_tmo_inc;
    logic [EW-1:0] w_err_base;
    logic [EW-1:0] w_err_nxt;

    comma_lane_detect #(
        .DATA_BYTES (DATA_BYTES)
    ) u_detect (
        .i_rxdata     (rxdata),
        .i_charisk    (rxcharisk),
        .i_disperr    (rxdisperr),
        .i_notintable (rxnotintable),
        .o_comma      (w_comma),
        .o_err        (w_err)
    );

    assign w_comma_inc = r_comma_cnt + 1'b1;
    assign w_tmo_inc   = r_tmo_cnt + 1'b1;
    assign w_wrap      = (r_win_cnt == WIN_MAX);
    assign w_err_base  = w_wrap ? '0 : r_err_cnt;

    // Error count after this cycle: window wrap clears first, then err adds
    always_comb begin
        w_err_nxt = w_err_base;
        if (w_err && (w_err_base != '1)) begin
            w_err_nxt = w_err_base + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; disable overrides everything
    always_comb begin
        w_next_state = r_state;
        w_loss       = 1'b0;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_HUNT;
                end
                ST_HUNT: begin
                    if (w_comma && rxbyteisaligned && !w_err) begin
                        w_next_state = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_err || !rxbyteisaligned) begin
                        w_next_state = ST_HUNT;
                    end else if (w_comma) begin
                        if (w_comma_inc == LC_LIM) begin
                            w_next_state = ST_LOCKED;
                        end
                    end else if (w_tmo_inc == TMO_LIM) begin
                        w_next_state = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (!rxbyteisaligned || (w_err_nxt >= ERR_LIM)) begin
                        w_next_state = ST_HUNT;
                        w_loss       = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Verify/timeout/window/error counters, seeded on state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_comma_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_win_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_state == ST_VERIFY) begin
                if (w_comma) begin
                    r_comma_cnt <= w_comma_inc;
                    r_tmo_cnt   <= '0;
                end else begin
                    r_tmo_cnt   <= w_tmo_inc;
                end
            end else begin
                r_comma_cnt <= CW'(1);
                r_tmo_cnt   <= '0;
            end
            if (r_state == ST_LOCKED) begin
                r_win_cnt <= w_wrap ? '0 : r_win_cnt + 1'b1;
                r_err_cnt <= w_err_nxt;
            end else begin
                r_win_cnt <= '0;
                r_err_cnt <= '0;
            end
        end
    end

    // Saturating count of lock losses; only rst clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != 16'hFFFF)) begin
            r_loss_cnt <= r_loss_cnt + 16'd1;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        rxcommaalignen_out = (r_state == ST_HUNT) || (r_state == ST_VERIFY);
        aligned            = (r_state == ST_LOCKED);
        align_state        = r_state;
        loss_count         = r_loss_cnt;
    end

endmodule

// File: tb/tb_rx_comma_align_ctrl.sv
// Directed bench for rx_comma_align_ctrl: vector table for the
// bring-up path plus hand sequences for window, timeout and reset cases.
module tb_rx_comma_align_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] rxdata;
    logic [1:0]  rxcharisk;
    logic [1:0]  rxdisperr;
    logic [1:0]  rxnotintable;
    logic        rxbyteisaligned;
    logic        rxcommaalignen_out;
    logic        aligned;
    logic [1:0]  align_state;
    logic [15:0] loss_count;

    int n_cmp;
    int n_bad;
    logic [15:0] exp_loss;

    localparam logic [15:0] D_IDLE = 16'h50BC;
    localparam logic [15:0] D_NOC  = 16'h5050;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] data;
        logic [1:0]  k;
        logic [1:0]  de;
        logic [1:0]  ni;
        logic        ba;
        logic        ae;
        logic        al;
        logic [1:0]  st;
        logic [15:0] loss;
    } vec_t;

    vec_t tv[$];

    rx_comma_align_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .rxdata             (rxdata),
        .rxcharisk          (rxcharisk),
        .rxdisperr          (rxdisperr),
        .rxnotintable       (rxnotintable),
        .rxbyteisaligned    (rxbyteisaligned),
        .rxcommaalignen_out (rxcommaalignen_out),
        .aligned            (aligned),
        .align_state        (align_state),
        .loss_count         (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic e, input logic [15:0] d,
        input logic [1:0] k, input logic [1:0] de, input logic [1:0] ni,
        input logic ba, input logic ae, input logic al,
        input logic [1:0] st, input logic [15:0] ls);
        vec_t v;
        v.rst = r; v.en = e; v.data = d; v.k = k; v.de = de;
        v.ni = ni; v.ba = ba; v.ae = ae; v.al = al; v.st = st;
        v.loss = ls;
        return v;
    endfunction

    task automatic drive(input logic e, input logic [15:0] d,
                         input logic [1:0] k, input logic [1:0] de,
                         input logic [1:0] ni, input logic ba);
        enable          = e;
        rxdata          = d;
        rxcharisk       = k;
        rxdisperr       = de;
        rxnotintable    = ni;
        rxbyteisaligned = ba;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic ae,
                           input logic al, input logic [1:0] st,
                           input logic [15:0] ls);
        chk(nm, {12'd0, rxcommaalignen_out, aligned, align_state, loss_count},
            {12'd0, ae, al, st, ls});
    endtask

    task automatic lock_up(input string nm);
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b00, 1'b1);
        repeat (4) step();
        chk_all(nm, 1'b0, 1'b1, 2'd3, exp_loss);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(1'b0, D_NOC, 2'b00, 2'b00, 2'b00, 1'b1);

        tv.push_back(mk(1,0,D_NOC, 2'b00,2'b00,2'b00,1, 0,0,2'd0,16'd0));
        tv.push_back(mk(0,0,D_IDLE,2'b01,2'b00,2'b00,1, 0,0,2'd0,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd1,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b10,2'b00,1, 1,0,2'd1,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 0,1,2'd3,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b01,1, 0,1,2'd3,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 0,1,2'd3,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b01,1, 0,1,2'd3,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b01,1, 0,1,2'd3,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 0,1,2'd3,16'd0));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b01,1, 1,0,2'd1,16'd1));
        tv.push_back(mk(0,0,D_IDLE,2'b01,2'b00,2'b00,1, 0,0,2'd0,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd1,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,0, 1,0,2'd1,16'd1));
        tv.push_back(mk(0,1,D_NOC, 2'b00,2'b00,2'b00,1, 1,0,2'd1,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b10,1, 1,0,2'd1,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,0, 1,0,2'd1,16'd1));
        tv.push_back(mk(0,1,16'hBC50,2'b10,2'b00,2'b00,1, 1,0,2'd2,16'd1));
        tv.push_back(mk(0,1,16'h50BC,2'b00,2'b00,2'b00,1, 1,0,2'd2,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 1,0,2'd2,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,1, 0,1,2'd3,16'd1));
        tv.push_back(mk(0,1,D_IDLE,2'b01,2'b00,2'b00,0, 1,0,2'd1,16'd2));

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst;
            drive(tv[i].en, tv[i].data, tv[i].k, tv[i].de,
                  tv[i].ni, tv[i].ba);
            step();
            chk_all($sformatf("vec%0d", i), tv[i].ae, tv[i].al,
                    tv[i].st, tv[i].loss);
        end
        exp_loss = 16'd2;

        // error window: 3 errs, wrap with err on the wrap cycle, 2 more
        lock_up("win_lock");
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b01, 1'b1);
        repeat (3) step();
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b00, 1'b1);
        repeat (1020) step();
        chk_all("win_pre_wrap", 1'b0, 1'b1, 2'd3, exp_loss);
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b01, 1'b1);
        repeat (3) step();
        chk_all("win_wrap_keep", 1'b0, 1'b1, 2'd3, exp_loss);
        step();
        exp_loss = exp_loss + 16'd1;
        chk_all("win_4th_err", 1'b1, 1'b0, 2'd1, exp_loss);

        // verify timeout
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b00, 1'b1);
        step();
        chk_all("tmo_enter", 1'b1, 1'b0, 2'd2, exp_loss);
        drive(1'b1, D_NOC, 2'b00, 2'b00, 2'b00, 1'b1);
        repeat (65534) step();
        chk_all("tmo_minus1", 1'b1, 1'b0, 2'd2, exp_loss);
        step();
        chk_all("tmo_expire", 1'b1, 1'b0, 2'd1, exp_loss);
        drive(1'b0, D_NOC, 2'b00, 2'b00, 2'b00, 1'b1);
        step();
        chk_all("disable_idle", 1'b0, 1'b0, 2'd0, exp_loss);

        // build loss_count up to 5, then reset while locked
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b00, 1'b1);
        step();
        chk_all("reenable", 1'b1, 1'b0, 2'd1, exp_loss);
        for (int j = 0; j < 2; j++) begin
            lock_up($sformatf("relock%0d", j));
            drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b00, 1'b0);
            step();
            exp_loss = exp_loss + 16'd1;
            chk_all($sformatf("baloss%0d", j), 1'b1, 1'b0, 2'd1, exp_loss);
        end
        lock_up("lock_loss5");
        rst = 1'b1;
        #2;
        chk_all("async_rst", 1'b0, 1'b0, 2'd0, 16'd0);
        step();
        chk_all("rst_hold", 1'b0, 1'b0, 2'd0, 16'd0);
        rst = 1'b0;
        exp_loss = 16'd0;
        step();
        chk_all("post_rst_hunt", 1'b1, 1'b0, 2'd1, exp_loss);

        // saturation of loss_count
        lock_up("sat_lock");
        force dut.r_loss_cnt = 16'hFFFF;
        #1;
        release dut.r_loss_cnt;
        exp_loss = 16'hFFFF;
        chk_all("sat_preset", 1'b0, 1'b1, 2'd3, exp_loss);
        drive(1'b1, D_IDLE, 2'b01, 2'b00, 2'b00, 1'b0);
        step();
        chk_all("sat_hold", 1'b1, 1'b0, 2'd1, exp_loss);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
